hbm_rd_req: RTL and testbench

HBM_RD_REQ -- requirements
Module: hbm_rd_req

---
 rtl/hbm_rd_req.sv | 196 +++++++++++++++++++
 tb/tb_hbm_rd_req.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_rd_req.sv
// rtl/hbm_rd_req.sv - HBM AXI3 read-request generator interleaving bursts from two regions
module hbm_rd_req #(
  parameter int                  ADDR_WIDTH      = 33,
  parameter int                  ID_WIDTH        = 6,
  parameter int                  BURST_LEN       = 8,
  parameter int                  MAX_OUTSTANDING = 16,
  parameter logic [ID_WIDTH-1:0] A_TAG           = 6'd0,
  parameter logic [ID_WIDTH-1:0] B_TAG           = 6'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base_addr,
  input  logic [ADDR_WIDTH-1:0] b_base_addr,
  input  logic [31:0]           a_length,
  input  logic [31:0]           b_length,
  output logic                  m_axi_ARVALID,
  input  logic                  m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [3:0]            m_axi_ARLEN,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  input  logic                  rd_burst_done,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           ar_a_counter,
  output logic [31:0]           ar_b_counter,
  output logic [4:0]            outstanding
);

  localparam int         BEAT_W      = 27;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;
  localparam logic [4:0] BURST_BEATS = 5'(BURST_LEN);
  localparam logic [4:0] MAX_OUT     = 5'(MAX_OUTSTANDING);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [BEAT_W-1:0]     a_rem_q, a_rem_d, b_rem_q, b_rem_d;
  logic                  turn_b_q, turn_b_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic                  ar_is_b_q, ar_is_b_d;
  logic [4:0]            out_q, out_d;
  logic [31:0]           a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic                  done_q, done_d;

  logic                  ar_hs;
  logic                  pick_b;
  logic [BEAT_W-1:0]     sel_rem;
  logic [4:0]            beats;
  logic [ADDR_WIDTH-1:0] step_bytes;
  logic                  work_left;
  logic                  slot_free;
  logic                  load;
  logic                  unused_len_bits;

  // Lengths are whole 32-byte beats, so their low bits carry no information.
  assign unused_len_bits = ^{a_length[4:0], b_length[4:0]};

  assign ar_hs      = arvalid_q & m_axi_ARREADY;
  assign pick_b     = (a_rem_q == '0) || (turn_b_q && (b_rem_q != '0));
  assign sel_rem    = pick_b ? b_rem_q : a_rem_q;
  assign beats      = (sel_rem >= BEAT_W'(BURST_LEN)) ? BURST_BEATS : sel_rem[4:0];
  assign step_bytes = ADDR_WIDTH'({beats, 5'b0_0000});
  assign work_left  = (a_rem_q != '0) || (b_rem_q != '0);
  assign slot_free  = !arvalid_q || ar_hs;
  // Capacity is judged on next-cycle occupancy so a freshly presented request never exceeds the limit.
  assign load       = (state_q == S_ISSUE) && slot_free && work_left && (out_d < MAX_OUT);

  always_comb begin
    out_d = out_q;
    if (ar_hs && !rd_burst_done) begin
      out_d = out_q + 5'd1;
    end else if (!ar_hs && rd_burst_done && (out_q != 5'd0)) begin
      out_d = out_q - 5'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    a_rem_d   = a_rem_q;
    b_rem_d   = b_rem_q;
    turn_b_d  = turn_b_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arid_d    = arid_q;
    ar_is_b_d = ar_is_b_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    done_d    = 1'b0;

    if (ar_hs) begin
      if (ar_is_b_q) b_cnt_d = b_cnt_q + 32'd1;
      else           a_cnt_d = a_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_addr_d = a_base_addr;
          b_addr_d = b_base_addr;
          a_rem_d  = a_length[31:5];
          b_rem_d  = b_length[31:5];
          turn_b_d = 1'b0;
          a_cnt_d  = 32'd0;
          b_cnt_d  = 32'd0;
          state_d  = ((a_length[31:5] != '0) || (b_length[31:5] != '0)) ? S_ISSUE : S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (slot_free) arvalid_d = 1'b0;
        if (ar_hs && !work_left) state_d = S_DRAIN;
        // Remaining beats and region address are committed when the request is presented.
        if (load) begin
          arvalid_d = 1'b1;
          araddr_d  = pick_b ? b_addr_q : a_addr_q;
          arlen_d   = 4'(beats - 5'd1);
          arid_d    = pick_b ? B_TAG : A_TAG;
          ar_is_b_d = pick_b;
          turn_b_d  = !pick_b;
          if (pick_b) begin
            b_rem_d  = b_rem_q - BEAT_W'(beats);
            b_addr_d = b_addr_q + step_bytes;
          end else begin
            a_rem_d  = a_rem_q - BEAT_W'(beats);
            a_addr_d = a_addr_q + step_bytes;
          end
        end
      end
      S_DRAIN: begin
        if (out_d == 5'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      a_rem_q   <= '0;
      b_rem_q   <= '0;
      turn_b_q  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      ar_is_b_q <= 1'b0;
      out_q     <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      a_rem_q   <= a_rem_d;
      b_rem_q   <= b_rem_d;
      turn_b_q  <= turn_b_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      ar_is_b_q <= ar_is_b_d;
      out_q     <= out_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      done_q    <= done_d;
    end
  end

  assign m_axi_ARVALID = arvalid_q;
  assign m_axi_ARADDR  = araddr_q;
  assign m_axi_ARLEN   = arlen_q;
  assign m_axi_ARID    = arid_q;
  assign m_axi_ARSIZE  = 3'b101;
  assign m_axi_ARBURST = 2'b01;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ar_a_counter  = a_cnt_q;
  assign ar_b_counter  = b_cnt_q;
  assign outstanding   = out_q;

endmodule

// File: tb/tb_hbm_rd_req.sv
// tb/tb_hbm_rd_req.sv - self-checking bench for hbm_rd_req
module tb_hbm_rd_req;
  localparam int AW = 33;
  localparam int IW = 6;
  localparam int BL = 8;
  localparam int MO = 16;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] a_base_addr, b_base_addr;
  logic [31:0]   a_length, b_length;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [3:0]    arlen;
  logic [IW-1:0] arid;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rd_burst_done, busy, done;
  logic [31:0]   a_cnt, b_cnt;
  logic [4:0]    outstanding;

  always #5 clk = ~clk;

  hbm_rd_req #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO),
    .A_TAG(6'd0), .B_TAG(6'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base_addr(a_base_addr), .b_base_addr(b_base_addr),
    .a_length(a_length), .b_length(b_length),
    .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr),
    .m_axi_ARLEN(arlen), .m_axi_ARID(arid), .m_axi_ARSIZE(arsize), .m_axi_ARBURST(arburst),
    .rd_burst_done(rd_burst_done), .busy(busy), .done(done),
    .ar_a_counter(a_cnt), .ar_b_counter(b_cnt), .outstanding(outstanding)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic [IW-1:0] id;
  } burst_t;

  typedef struct {
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [31:0]   a_len;
    logic [31:0]   b_len;
    int            rdy;
    int            rsp;
    bit            spur;
    int            exp_a;
    int            exp_b;
  } vec_t;

  burst_t exp_q[$];
  burst_t qa[$];
  burst_t qb[$];
  vec_t   tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void chunk(input logic [AW-1:0] base, input logic [31:0] len,
                                input logic [IW-1:0] id, input bit to_b);
    int            left;
    int            n;
    logic [AW-1:0] addr;
    burst_t        b;
    left = int'(len >> 5);
    addr = base;
    while (left > 0) begin
      n = (left > BL) ? BL : left;
      b.addr = addr;
      b.len  = 4'(n - 1);
      b.id   = id;
      if (to_b) qb.push_back(b);
      else      qa.push_back(b);
      addr = addr + AW'(n * 32);
      left = left - n;
    end
  endfunction

  // Expected AR stream: per-region chunk lists merged A,B,A,B until one list runs dry.
  function automatic void build_model(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                      input logic [31:0] al, input logic [31:0] bl);
    qa.delete();
    qb.delete();
    exp_q.delete();
    chunk(ab, al, 6'd0, 1'b0);
    chunk(bb, bl, 6'd1, 1'b1);
    while (qa.size() > 0 || qb.size() > 0) begin
      if (qa.size() > 0) exp_q.push_back(qa.pop_front());
      if (qb.size() > 0) exp_q.push_back(qb.pop_front());
    end
  endfunction

  function automatic int nbursts(input logic [31:0] len);
    return (int'(len >> 5) + BL - 1) / BL;
  endfunction

  task automatic run_job(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [31:0] al, input logic [31:0] bl,
                         input int rdy, input int rsp, input bit spur,
                         input int exp_a, input int exp_b, input string tag);
    int            mout, n_a, n_b;
    bit            done_seen, exp_done, exp_valid, stall, hs, rd;
    logic [AW-1:0] h_addr;
    logic [3:0]    h_len;
    logic [IW-1:0] h_id;
    burst_t        f;
    build_model(ab, bb, al, bl);
    a_base_addr = ab; b_base_addr = bb; a_length = al; b_length = bl;
    start = 1'b1; arready = 1'b0; rd_burst_done = 1'b0;
    step();
    start = 1'b0;
    mout = 0; n_a = 0; n_b = 0;
    done_seen = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; stall = 1'b0;
    h_addr = '0; h_len = '0; h_id = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      chk({tag, " done"}, 64'(done), 64'(exp_done));
      chk({tag, " busy"}, 64'(busy), 64'(!exp_done));
      chk({tag, " outstanding"}, 64'(outstanding), 64'(mout));
      if (stall) begin
        chk({tag, " hold_valid"}, 64'(arvalid), 64'(1));
        chk({tag, " hold_addr"}, 64'(araddr), 64'(h_addr));
        chk({tag, " hold_len"}, 64'(arlen), 64'(h_len));
        chk({tag, " hold_id"}, 64'(arid), 64'(h_id));
      end
      if (exp_valid) chk({tag, " back_to_back"}, 64'(arvalid), 64'(1));
      if (arvalid) begin
        chk({tag, " cap"}, 64'(mout < MO), 64'(1));
        chk({tag, " unexpected_arvalid"}, 64'(exp_q.size() != 0), 64'(1));
      end
      if (exp_done) begin
        done_seen = 1'b1;
        break;
      end
      arready = ($urandom_range(99) < rdy);
      hs = arvalid && arready;
      rd = (mout > 0) && ($urandom_range(99) < rsp);
      if (spur && mout == 0 && !hs && $urandom_range(7) == 0) rd = 1'b1;
      rd_burst_done = rd;
      start = (cyc == 3);
      if (cyc == 3) begin
        a_length = $urandom;
        b_length = $urandom;
      end
      if (hs && exp_q.size() > 0) begin
        f = exp_q.pop_front();
        chk({tag, " araddr"}, 64'(araddr), 64'(f.addr));
        chk({tag, " arlen"}, 64'(arlen), 64'(f.len));
        chk({tag, " arid"}, 64'(arid), 64'(f.id));
        if (f.id == 6'd1) n_b++;
        else              n_a++;
      end
      if (hs && !rd)                  mout++;
      else if (!hs && rd && mout > 0) mout--;
      exp_valid = hs && (exp_q.size() > 0) && (mout < MO);
      stall  = arvalid && !arready;
      h_addr = araddr; h_len = arlen; h_id = arid;
      exp_done = (exp_q.size() == 0) && (mout == 0);
      step();
    end
    arready = 1'b0; rd_burst_done = 1'b0; start = 1'b0;
    chk({tag, " done_seen"}, 64'(done_seen), 64'(1));
    chk({tag, " a_handshakes"}, 64'(n_a), 64'(exp_a));
    chk({tag, " b_handshakes"}, 64'(n_b), 64'(exp_b));
    chk({tag, " ar_a_counter"}, 64'(a_cnt), 64'(exp_a));
    chk({tag, " ar_b_counter"}, 64'(b_cnt), 64'(exp_b));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, cnt;
    rst_n = 1'b0; start = 1'b0; arready = 1'b0; rd_burst_done = 1'b0;
    a_base_addr = '0; b_base_addr = '0; a_length = '0; b_length = '0;
    step(); step();
    chk("rst arvalid", 64'(arvalid), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst outstanding", 64'(outstanding), 64'(0));
    chk("rst a_cnt", 64'(a_cnt), 64'(0));
    chk("rst b_cnt", 64'(b_cnt), 64'(0));
    chk("rst araddr", 64'(araddr), 64'(0));
    chk("rst arlen", 64'(arlen), 64'(0));
    chk("rst arid", 64'(arid), 64'(0));
    chk("arsize", 64'(arsize), 64'(3'b101));
    chk("arburst", 64'(arburst), 64'(2'b01));
    rst_n = 1'b1;

    // ARREADY held low: request must stay frozen and count once.
    a_base_addr = 33'h0_0001_0000; a_length = 32'd512; b_length = 32'd0;
    start = 1'b1; step(); start = 1'b0;
    waited = 0;
    while (!arvalid && waited < 10) begin step(); waited++; end
    chk("stall arvalid_seen", 64'(arvalid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("stall arvalid", 64'(arvalid), 64'(1));
      chk("stall araddr", 64'(araddr), 64'(33'h0_0001_0000));
      chk("stall arlen", 64'(arlen), 64'(7));
      chk("stall arid", 64'(arid), 64'(0));
      chk("stall a_cnt", 64'(a_cnt), 64'(0));
      step();
    end
    arready = 1'b1; step(); arready = 1'b0;
    chk("stall a_cnt_after", 64'(a_cnt), 64'(1));
    chk("stall outstanding", 64'(outstanding), 64'(1));
    step(); step();
    chk("stall a_cnt_once", 64'(a_cnt), 64'(1));
    chk("stall next_addr", 64'(araddr), 64'(33'h0_0001_0100));
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // Outstanding cap with no responses, then release one slot at a time.
    a_base_addr = '0; a_length = 32'd5120; b_length = 32'd0;
    arready = 1'b1; start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (arvalid && arready) cnt++;
      step();
    end
    chk("cap handshakes", 64'(cnt), 64'(16));
    chk("cap arvalid_low", 64'(arvalid), 64'(0));
    chk("cap outstanding", 64'(outstanding), 64'(16));
    rd_burst_done = 1'b1; step(); rd_burst_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (arvalid && arready) cnt++;
      step();
    end
    chk("cap one_more", 64'(cnt), 64'(1));
    chk("cap arvalid_low2", 64'(arvalid), 64'(0));
    arready = 1'b0; rd_burst_done = 1'b1; step(); rd_burst_done = 1'b0;
    chk("cap arvalid_release", 64'(arvalid), 64'(1));
    chk("cap outstanding_15", 64'(outstanding), 64'(15));
    arready = 1'b1; rd_burst_done = 1'b1; step(); arready = 1'b0; rd_burst_done = 1'b0;
    chk("coincident outstanding", 64'(outstanding), 64'(15));
    chk("coincident a_cnt", 64'(a_cnt), 64'(18));

    // Reset in the middle of a job.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a_length = 32'd5120; arready = 1'b1; start = 1'b1; step(); start = 1'b0;
    waited = 0;
    while (!(outstanding == 5'd5 && arvalid) && waited < 40) begin step(); waited++; end
    chk("midrst setup", 64'(outstanding), 64'(5));
    arready = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst arvalid", 64'(arvalid), 64'(0));
    chk("midrst outstanding", 64'(outstanding), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst a_cnt", 64'(a_cnt), 64'(0));

    tbl[0] = '{33'h1_0000_0000, 33'h0,           32'd512,  32'd0,    100, 100, 1'b0, 2,  0};
    tbl[1] = '{33'h0_0000_2000, 33'h0_0000_8000, 32'd768,  32'd768,  100, 50,  1'b0, 3,  3};
    tbl[2] = '{33'h0_0000_0040, 33'h0,           32'd96,   32'd0,    100, 100, 1'b0, 1,  0};
    tbl[3] = '{33'h0,           33'h0,           32'd0,    32'd0,    100, 100, 1'b1, 0,  0};
    tbl[4] = '{33'h0,           33'h0_1234_5660, 32'd0,    32'd1024, 60,  40,  1'b1, 0,  4};
    tbl[5] = '{33'h0_0000_0300, 33'h0_0000_0900, 32'd288,  32'd64,   70,  30,  1'b1, 2,  1};
    tbl[6] = '{33'h0_FFFF_F000, 33'h0_0000_4000, 32'd5120, 32'd96,   100, 5,   1'b0, 20, 1};
    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i].a_base, tbl[i].b_base, tbl[i].a_len, tbl[i].b_len,
              tbl[i].rdy, tbl[i].rsp, tbl[i].spur, tbl[i].exp_a, tbl[i].exp_b,
              $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 12; r++) begin
      logic [AW-1:0] ab, bb;
      logic [31:0]   al, bl;
      ab = {1'($urandom_range(1)), $urandom} & ~33'h1F;
      bb = {1'($urandom_range(1)), $urandom} & ~33'h1F;
      al = 32'($urandom_range(40)) << 5;
      bl = (r % 4 == 1) ? 32'd0 : (32'($urandom_range(40)) << 5);
      run_job(ab, bb, al, bl, int'($urandom_range(30, 100)), int'($urandom_range(10, 90)),
              1'($urandom_range(1)), nbursts(al), nbursts(bl), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
